// File: rtl/axis_dds_pkg.sv
// Shared widths, quadrant encoding and the elaboration-time quarter-wave ROM generator
// for the NCO phase-to-amplitude stage.
package axis_dds_pkg;

    localparam int unsigned DEF_AXIS_TDATA_WIDTH   = 32;
    localparam int unsigned DEF_PHASE_WIDTH        = 30;
    localparam int unsigned DEF_LUT_ADDR_WIDTH     = 10;
    localparam int unsigned DEF_AMPL_WIDTH         = 16;
    localparam int unsigned DEF_M_AXIS_TDATA_WIDTH = 32;

    localparam int unsigned AMPL_MAX = 2 ** (DEF_AMPL_WIDTH - 1) - 1;

    typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quadrant_e;

    // pi in unsigned Q60 fixed point
    localparam logic [63:0] PI_Q60 = 64'h3243F6A8885A308D;

    // round(AMPL_MAX * sin(pi/2 * (idx+0.5) / 2^addr_w)) using a Q60 Taylor series, so
    // the table is built from integer arithmetic only.
    function automatic logic [31:0] rom_value(input int unsigned idx,
                                              input int unsigned addr_w,
                                              input int unsigned ampl_w);
        logic [127:0] x;
        logic [127:0] x2;
        logic [127:0] term;
        logic [127:0] pos;
        logic [127:0] neg;
        logic [127:0] scaled;
        x    = (128'(PI_Q60) * 128'(2 * idx + 1)) >> (addr_w + 2);
        x2   = (x * x) >> 60;
        term = x;
        pos  = x;
        neg  = '0;
        for (int k = 1; k <= 11; k++) begin
            term = ((term * x2) >> 60) / 128'((2 * k) * (2 * k + 1));
            if (k % 2 == 1) neg = neg + term;
            else            pos = pos + term;
        end
        scaled = (pos - neg) * 128'((1 << (ampl_w - 1)) - 1) + (128'(1) << 59);
        return 32'(scaled >> 60);
    endfunction

endpackage

// File: rtl/sincos_quarter_rom.sv
// Dual-read quarter-wave sine ROM; both ports register their data under a shared enable.
module sincos_quarter_rom
    import axis_dds_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_LUT_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_AMPL_WIDTH
) (
    input  logic                  clk,
    input  logic                  ce,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    output logic [DATA_WIDTH-1:0] data_a,
    output logic [DATA_WIDTH-1:0] data_b
);

    logic [DATA_WIDTH-1:0] rom [2**ADDR_WIDTH];

    for (genvar i = 0; i < 2 ** ADDR_WIDTH; i++) begin : g_rom
        localparam logic [31:0] VALUE = rom_value(i, ADDR_WIDTH, DATA_WIDTH);
        assign rom[i] = VALUE[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (ce) begin
            data_a <= rom[addr_a];
            data_b <= rom[addr_b];
        end
    end

endmodule

// File: rtl/axis_phase_to_sincos.sv
// AXI4-Stream phase word to packed {cos, sin} amplitude pair; three-stage pipeline
// (index/quadrant, ROM read, sign/pack) with a single global enable for backpressure.
module axis_phase_to_sincos
    import axis_dds_pkg::*;
#(
    parameter int unsigned AXIS_TDATA_WIDTH   = DEF_AXIS_TDATA_WIDTH,
    parameter int unsigned PHASE_WIDTH        = DEF_PHASE_WIDTH,
    parameter int unsigned LUT_ADDR_WIDTH     = DEF_LUT_ADDR_WIDTH,
    parameter int unsigned AMPL_WIDTH         = DEF_AMPL_WIDTH,
    parameter int unsigned M_AXIS_TDATA_WIDTH = DEF_M_AXIS_TDATA_WIDTH
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic [M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready
);

    localparam int unsigned IDX_WIDTH = LUT_ADDR_WIDTH + 2;

    logic                      ce;
    logic                      unused_tdata;
    logic [IDX_WIDTH-1:0]      phase_idx;
    logic [LUT_ADDR_WIDTH-1:0] addr;
    quadrant_e                 q_sin;
    quadrant_e                 q_cos;

    logic                      valid_s0;
    logic                      valid_s1;
    quadrant_e                 q_sin_s0;
    quadrant_e                 q_cos_s0;
    logic [LUT_ADDR_WIDTH-1:0] addr_sin_s0;
    logic [LUT_ADDR_WIDTH-1:0] addr_cos_s0;
    logic                      neg_sin_s1;
    logic                      neg_cos_s1;
    logic [AMPL_WIDTH-1:0]     rom_sin;
    logic [AMPL_WIDTH-1:0]     rom_cos;
    logic [AMPL_WIDTH-1:0]     sin_val;
    logic [AMPL_WIDTH-1:0]     cos_val;

    // Odd quadrants read the quarter wave backwards.
    function automatic logic [LUT_ADDR_WIDTH-1:0] fold_addr(input quadrant_e q,
                                                           input logic [LUT_ADDR_WIDTH-1:0] a);
        return (q == Q1 || q == Q3) ? ~a : a;
    endfunction

    assign ce            = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = ce || areset;

    // Upper sign-extension bits and truncated fraction bits are intentionally ignored.
    assign unused_tdata  = ^s_axis_tdata;
    assign phase_idx     = s_axis_tdata[PHASE_WIDTH-1 -: IDX_WIDTH];
    assign addr          = phase_idx[LUT_ADDR_WIDTH-1:0];
    assign q_sin         = quadrant_e'(phase_idx[IDX_WIDTH-1 -: 2]);
    assign q_cos         = quadrant_e'(phase_idx[IDX_WIDTH-1 -: 2] + 2'd1);

    always_ff @(posedge aclk) begin
        if (areset) begin
            valid_s0      <= 1'b0;
            valid_s1      <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
        end else if (ce) begin
            valid_s0      <= s_axis_tvalid;
            valid_s1      <= valid_s0;
            m_axis_tvalid <= valid_s1;
            if (valid_s1) m_axis_tdata <= {cos_val, sin_val};
        end
    end

    always_ff @(posedge aclk) begin
        if (ce) begin
            q_sin_s0    <= q_sin;
            q_cos_s0    <= q_cos;
            addr_sin_s0 <= fold_addr(q_sin, addr);
            addr_cos_s0 <= fold_addr(q_cos, addr);
            neg_sin_s1  <= (q_sin_s0 == Q2 || q_sin_s0 == Q3);
            neg_cos_s1  <= (q_cos_s0 == Q2 || q_cos_s0 == Q3);
        end
    end

    sincos_quarter_rom #(
        .ADDR_WIDTH (LUT_ADDR_WIDTH),
        .DATA_WIDTH (AMPL_WIDTH)
    ) u_rom (
        .clk    (aclk),
        .ce     (ce),
        .addr_a (addr_sin_s0),
        .addr_b (addr_cos_s0),
        .data_a (rom_sin),
        .data_b (rom_cos)
    );

    // ROM entries never exceed 2^(AMPL_WIDTH-1)-1, so negation cannot overflow.
    assign sin_val = neg_sin_s1 ? -rom_sin : rom_sin;
    assign cos_val = neg_cos_s1 ? -rom_cos : rom_cos;

endmodule

// File: tb/tb_axis_phase_to_sincos.sv
// Directed bench for axis_phase_to_sincos: hand-computed vectors, reset/bubble sequences,
// and full-circle sweeps without and with random backpressure against a trig model.
module tb_axis_phase_to_sincos;

    localparam real PI = 3.14159265358979323846;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;

    int checks = 0;
    int errors = 0;

    axis_phase_to_sincos dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        string       name;
        logic [31:0] phase;
        logic [31:0] expected;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] rnd(input real v);
        int r;
        r = (v >= 0.0) ? int'($floor(v + 0.5)) : -int'($floor(-v + 0.5));
        return 16'(r);
    endfunction

    // Half-step offset angle: {cos, sin} = round(32767 * trig(2*pi*(p+0.5)/4096)).
    function automatic logic [31:0] model(input logic [31:0] ph);
        int  p;
        real th;
        p  = int'(ph[29:18]);
        th = 2.0 * PI * (real'(p) + 0.5) / 4096.0;
        return {rnd(32767.0 * $cos(th)), rnd(32767.0 * $sin(th))};
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic run_stream(input int stall_pct, input string tag);
        int          in_idx = 0;
        int          out_idx = 0;
        int          cyc = 0;
        logic        stalled = 1'b0;
        logic [31:0] held = '0;
        real         s;
        real         c;
        real         err;
        while (out_idx < 4096 && cyc < 20000) begin
            m_axis_tready = ($urandom_range(0, 99) >= stall_pct);
            s_axis_tvalid = (in_idx < 4096);
            s_axis_tdata  = 32'(in_idx) * 32'h0004_0000;
            @(negedge aclk);
            check({tag, "_tready_rule"}, 32'(s_axis_tready),
                  32'(!m_axis_tvalid || m_axis_tready));
            if (stalled) begin
                check({tag, "_stall_valid"}, 32'(m_axis_tvalid), 32'd1);
                check({tag, "_stall_hold"}, m_axis_tdata, held);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                check({tag, "_sample"}, m_axis_tdata, model(32'(out_idx) * 32'h0004_0000));
                s   = real'($signed(m_axis_tdata[15:0]));
                c   = real'($signed(m_axis_tdata[31:16]));
                err = $sqrt(s * s + c * c) - 32767.0;
                checks++;
                if (err > 2.0 || err < -2.0) begin
                    errors++;
                    $display("FAIL %s_magnitude: index %0d got %f expected 32767 +/-2",
                             tag, out_idx, $sqrt(s * s + c * c));
                end
                out_idx++;
            end
            stalled = m_axis_tvalid && !m_axis_tready;
            held    = m_axis_tdata;
            if (s_axis_tvalid && s_axis_tready) in_idx++;
            tick();
            cyc++;
        end
        check({tag, "_count"}, 32'(out_idx), 32'd4096);
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge aclk);
            check({tag, "_no_extra"}, 32'(m_axis_tvalid), 32'd0);
            tick();
        end
    endtask

    initial begin
        logic [31:0] got [$];
        logic [31:0] rst_ph [5];

        vecs[0] = '{"q0_point",   32'h0000_0000, 32'h7FFF_0019};
        vecs[1] = '{"q1_point",   32'h1000_0000, 32'hFFE7_7FFF};
        vecs[2] = '{"q2_point",   32'h2000_0000, 32'h8001_FFE7};
        vecs[3] = '{"q3_point",   32'h3000_0000, 32'h0019_8001};
        vecs[4] = '{"trunc_upper", 32'hC003_FFFF, 32'h7FFF_0019};

        areset        = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        tick();
        tick();
        check("reset_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("reset_tdata", m_axis_tdata, 32'd0);
        check("reset_tready", 32'(s_axis_tready), 32'd1);
        areset = 1'b0;
        tick();

        // Single phases: result valid after the third rising edge from acceptance.
        foreach (vecs[i]) begin
            s_axis_tdata  = vecs[i].phase;
            s_axis_tvalid = 1'b1;
            tick();
            s_axis_tvalid = 1'b0;
            tick();
            tick();
            check({vecs[i].name, "_valid"}, 32'(m_axis_tvalid), 32'd1);
            check(vecs[i].name, m_axis_tdata, vecs[i].expected);
            tick();
        end

        // Bubbles: tvalid 1,0,1 in cycles 0..2 -> valid outputs in cycles 3 and 5 only.
        s_axis_tdata  = 32'h1000_0000;
        s_axis_tvalid = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
        tick();
        s_axis_tdata  = 32'h3000_0000;
        s_axis_tvalid = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
        for (int k = 3; k <= 7; k++) begin
            check($sformatf("bubble_valid_c%0d", k), 32'(m_axis_tvalid),
                  32'(k == 3 || k == 5));
            if (k == 3) check("bubble_first", m_axis_tdata, 32'hFFE7_7FFF);
            if (k == 5) check("bubble_second", m_axis_tdata, 32'h0019_8001);
            tick();
        end

        // Reset mid-stream: five phases, reset during cycle 2; only phases 3 and 4 survive.
        rst_ph = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h0800_0000, 32'h3000_0000};
        for (int k = 0; k < 5; k++) begin
            s_axis_tdata  = rst_ph[k];
            s_axis_tvalid = 1'b1;
            areset        = (k == 2);
            tick();
            if (k == 2) begin
                check("midreset_tvalid", 32'(m_axis_tvalid), 32'd0);
                check("midreset_tdata", m_axis_tdata, 32'd0);
            end
        end
        areset        = 1'b0;
        s_axis_tvalid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge aclk);
            if (m_axis_tvalid) got.push_back(m_axis_tdata);
            tick();
        end
        check("midreset_count", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            check("midreset_first", got[0], model(rst_ph[3]));
            check("midreset_second", got[1], model(rst_ph[4]));
        end

        run_stream(0, "sweep");
        run_stream(30, "bp");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_phase_to_sincos.md
Name: axis_phase_to_sincos

Overview:
Downstream stage of the NCO phase accumulator. Consumes the AXI4-Stream phase word and emits a packed cosine/sine amplitude pair on a second AXI4-Stream.
- Conversion uses a quarter-wave ROM plus quadrant symmetry.
- Three-stage registered pipeline with full backpressure.
- Feeds the DDS output mixer / DAC formatting stage.

Parameters:
AXIS_TDATA_WIDTH, 32, input stream width; phase is in the low PHASE_WIDTH bits, upper bits are don't-care (sign extension).
PHASE_WIDTH, 30, phase accumulator width; must be >= LUT_ADDR_WIDTH+2.
LUT_ADDR_WIDTH, 10, quarter-wave ROM address width (2^LUT_ADDR_WIDTH entries).
AMPL_WIDTH, 16, signed amplitude width per component.
M_AXIS_TDATA_WIDTH, 32, output width; must equal 2*AMPL_WIDTH.

Ports:
aclk  in  1  clock; all logic on rising edge.
areset  in  1  synchronous, active-high reset.
s_axis_tdata  in  AXIS_TDATA_WIDTH  phase word.
s_axis_tvalid  in  1  phase valid.
s_axis_tready  out  1  phase accepted when tvalid && tready.
m_axis_tdata  out  M_AXIS_TDATA_WIDTH  {cos[AMPL_WIDTH-1:0], sin[AMPL_WIDTH-1:0]}, two's complement.
m_axis_tvalid  out  1  output valid.
m_axis_tready  in  1  downstream ready.

Behaviour:
- Reset (areset high at a clock edge):
  - All stage valids and m_axis_tvalid become 0; m_axis_tdata becomes 0.
  - In-flight samples are discarded; no partial output after reset.
  - s_axis_tready is 1 during and after reset (pipeline empty).
- Phase index: p = s_axis_tdata[PHASE_WIDTH-1 -: LUT_ADDR_WIDTH+2]. Lower phase bits are truncated, not rounded.
- Quadrant and address: q = p[MSB:MSB-1]; a = p[LUT_ADDR_WIDTH-1:0].
- ROM contents: ROM[i] = round((2^(AMPL_WIDTH-1)-1) * sin(pi/2 * (i+0.5) / 2^LUT_ADDR_WIDTH)). ROM is unsigned with max 2^(AMPL_WIDTH-1)-1, so the negated value never overflows.
- Sine:
  - q=0: +ROM[a]
  - q=1: +ROM[~a]
  - q=2: -ROM[a]
  - q=3: -ROM[~a]
- Cosine: same mapping applied with q+1 mod 4. Both lookups happen in parallel (dual-read ROM).
- Pipeline:
  - S0 registers q_sin, q_cos and both addresses.
  - S1 performs the synchronous ROM read; the quadrant sign bits are carried alongside.
  - S2 applies conditional negation and packs the result into m_axis_tdata.
- Flow control:
  - ce = !m_axis_tvalid || m_axis_tready.
  - s_axis_tready = ce.
  - All stages, including their valid bits, advance only when ce=1.
  - Latency from input handshake to m_axis_tvalid is 3 cycles with no stall.
  - Throughput is 1 sample/cycle while m_axis_tready stays high.
- Stall: while m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata and all stage registers hold. No sample is lost or duplicated.
- Bubbles: input tvalid=0 with ce=1 inserts an invalid slot. Bubbles are not collapsed.
- Simultaneous events: output handshake and input acceptance in the same cycle are both legal.
- Phase wrap: phase 2^PHASE_WIDTH-1 followed by 0 requires no special handling.
- Input tdata upper bits are ignored; no checking is performed.

Decomposition:
- Package axis_dds_pkg holds:
  - default widths;
  - the quadrant enum (Q0..Q3);
  - the function computing ROM[i] at elaboration time;
  - the localparam AMPL_MAX = 2^(AMPL_WIDTH-1)-1.
- Sub-module sincos_quarter_rom:
  - two synchronous read ports with a shared ce;
  - contents initialised from the package function;
  - no reset on the data registers.

Test Plan:
- Reset mid-stream: drive 5 phases, assert areset on cycle 2 -> m_axis_tvalid=0 and tdata=0 next cycle; no stale samples emitted afterwards.
- Quadrant points (defaults), m_axis_tready=1:
  - phase 0x00000000 -> 0x7FFF0019 after 3 cycles;
  - phase 0x10000000 -> 0xFFE77FFF;
  - phase 0x20000000 -> 0x8001FFE7;
  - phase 0x30000000 -> 0x0019 8001, i.e. 0x00198001.
- Full sweep: connect the phase generator with cfg_data=0x00040000 (one ROM step) for 4096 samples -> every sample matches the golden model; sin^2+cos^2 within +/-2 LSB of 32767^2 scale; all 4096 indices produced once.
- Backpressure: random m_axis_tready at 30% with continuous input -> output sequence identical to the no-stall run; tdata stable while tvalid && !tready; s_axis_tready == !m_axis_tvalid || m_axis_tready every cycle.
- Truncation/upper bits: phase 0x0003FFFF with tdata[31:30]=2'b11 -> same output as phase 0 (0x7FFF0019).
- Bubbles: tvalid pattern 1,0,1 -> outputs valid on cycles 3 and 5 only, in order.
